exu_seq: RTL

Handshake sequencer for the execute stage. Sits between IDU and the EXU result register block: accepts decoded instructions with valid/ready, starts the iterative mul/div unit when needed, strobes the EXU result register's capture enable when the result is ready, and presents the result downstream with valid/ready. Also raises a one-cycle front-end redirect when a taken jump/branch/trap is handed off, detects mul/div timeouts, and counts retired handoffs.

---
 rtl/exu_seq.sv | 89 ++++++++
 1 files changed

// File: rtl/exu_seq.sv
// Execute-stage handshake sequencer: accepts IDU instructions, runs the iterative
// mul/div unit when needed, strobes result capture and hands results downstream.
module exu_seq #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_mdu_op,
  output logic        o_mdu_start,
  input  logic        i_mdu_done,
  output logic        o_mdu_kill,
  output logic        o_capture,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  input  logic        i_jump,
  output logic        o_redirect,
  input  logic        i_flush,
  output logic        o_timeout,
  output logic [31:0] o_inst_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic       accept, handoff, timeout_hit, in_wait;

  assign in_wait     = (state == WAIT);
  assign o_in_ready  = ~i_flush & ((state == IDLE) | ((state == DONE) & i_out_ready & ~i_jump));
  // Reset gates accept so no start/capture escapes while reset is held low.
  assign accept      = i_in_valid & o_in_ready & i_reset;
  assign o_out_valid = (state == DONE) & ~i_flush;
  assign handoff     = o_out_valid & i_out_ready;
  assign timeout_hit = in_wait & (cnt == CNT_W'(TIMEOUT)) & ~i_mdu_done;

  assign o_mdu_start = accept & i_mdu_op;
  assign o_capture   = (accept & ~i_mdu_op) | (in_wait & i_mdu_done & ~i_flush);
  assign o_redirect  = handoff & i_jump;
  assign o_mdu_kill  = in_wait & (i_flush | timeout_hit);

  always_comb begin
    // NOTE: defaults first so every path assigns state_n/cnt_n and no latch is inferred.
    state_n = state;
    cnt_n   = cnt;
    if (i_flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          state_n = i_mdu_op ? WAIT : DONE;
          cnt_n   = '0;
        end
        WAIT: begin
          if (i_mdu_done)       state_n = DONE;
          else if (timeout_hit) state_n = IDLE;
          else                  cnt_n   = cnt + 1'b1;
        end
        DONE: begin
          if (handoff & accept) begin
            state_n = i_mdu_op ? WAIT : DONE;
            cnt_n   = '0;
          end else if (handoff) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      o_timeout  <= 1'b0;
      o_inst_cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (timeout_hit & ~i_flush) o_timeout <= 1'b1;
      if (handoff) o_inst_cnt <= o_inst_cnt + 32'd1;
    end
  end

endmodule
